imem_loader: RTL
================

Name: imem_loader

Overview:
- Program loader for the multi-cycle core: receives a byte-serial instruction image, assembles 32-bit words and writes them into the instruction memory through the core's memory port (mem_lo / mem_in / mem_en).
- It is the writer side of that memory; the core is the reader.
- After the last word is committed it pulses core_start, which drives the core's start input, and reports completion.
- It drives the memory only while loading; the top level muxes memory ownership on busy.

Parameters:
- NUM_WORDS, 48, number of 32-bit words in the image (1..256); last address is NUM_WORDS-1.
- WR_HOLD, 2, cycles mem_en is held high per word (1..7); covers the synchronous memory write.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous active-low reset.
- load_go  input  1  request to begin a load; sampled in IDLE and DONE only.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  image byte, little-endian within each word.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_lo  output  8  memory word address.
- mem_in  output  32  memory write data.
- mem_en  output  1  memory write enable.
- core_start  output  1  one-cycle pulse to the core after the image is complete.
- busy  output  1  loader owns the memory port (COLLECT, WRITE, NEXT).
- load_done  output  1  image fully written; held until the next load_go.
- word_count  output  8  number of words committed in the current load.
- checksum  output  32  running XOR of all committed words; cleared on load_go.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0. Byte index=0 and assembly register=0.
- Byte handshake:
  - A byte transfers on a posedge where byte_valid && byte_ready.
  - byte_ready=1 only in COLLECT.
  - The sender holds byte_data and byte_valid until the transfer. byte_valid outside COLLECT has no effect.
- Word assembly: byte k (k=0..3) of a word goes to bits [8k+7:8k]. After byte 3 is accepted the full word is in the assembly register.
- State machine:
  - IDLE: on load_go → COLLECT. Clear word_count, checksum, mem_lo and byte index.
  - COLLECT: accept bytes. On the 4th accepted byte → WRITE; mem_in takes the assembled word on the same edge.
  - WRITE: mem_en=1 for exactly WR_HOLD consecutive cycles, with mem_lo and mem_in stable throughout. On the last hold cycle → NEXT.
  - NEXT (1 cycle): mem_en=0. word_count+=1. checksum^=mem_in.
    - If word_count+1 == NUM_WORDS → START_CORE.
    - Otherwise mem_lo+=1, byte index=0, → COLLECT.
  - START_CORE (1 cycle): core_start=1, busy=0 → DONE.
  - DONE: load_done=1. On load_go → COLLECT with the same clears as IDLE; load_done drops on that edge.
- Latency: from the 4th byte accepted to mem_en rising is 1 cycle. mem_en stays high WR_HOLD cycles, then NEXT takes 1 cycle. The minimum word period is 4+WR_HOLD+1 cycles.
- Boundary conditions:
  - load_go during COLLECT, WRITE or NEXT is ignored.
  - No address wrap: mem_lo never exceeds NUM_WORDS-1.
  - NUM_WORDS=1: after one word → START_CORE.
  - Reset mid-write: mem_en drops immediately and the partially loaded image is abandoned; there is no resume.
  - byte_valid held high in NEXT or WRITE is not consumed.
- Widths: word_count and mem_lo are 8-bit; checksum is 32-bit XOR with no carry.

Decomposition:
- Shared package:
  - state encodings IDLE=0, COLLECT=1, WRITE=2, NEXT=3, START_CORE=4, DONE=5 (4-bit, matching the core's state width);
  - constant IMEM_ADDR_W=8;
  - constant IMEM_DATA_W=32.
- One natural sub-module: byte_packer (byte index counter plus 4-byte little-endian assembly register, emits word_valid). The FSM stays in imem_loader.

Test Plan:
- NUM_WORDS=2, WR_HOLD=2. load_go, then bytes 13 05 10 00 → mem_lo=0, mem_in=0x00100513, mem_en high exactly 2 cycles. Next bytes B3 05 A5 00 → mem_lo=1, mem_in=0x00A505B3. Then core_start pulses 1 cycle, load_done=1, word_count=2, checksum=0x00B500A0.
- Sender stalls by dropping byte_valid between bytes 1 and 2 for 5 cycles → word unchanged and byte_ready still 1; mem_en only after the 4th byte.
- byte_valid held high continuously → byte_ready=0 during WRITE and NEXT; exactly 4 bytes consumed per word; no byte lost or duplicated.
- load_go asserted while in WRITE → ignored: word_count and mem_lo continue normally and load_done is not cleared.
- rst=0 during the 2nd WRITE cycle → mem_en, busy and mem_lo go to 0 asynchronously; after release state=IDLE and byte_ready=0 until load_go.
- From DONE, load_go with NUM_WORDS=1, word 0xFFFFFFFF → load_done drops, word written at mem_lo=0, core_start pulses again, checksum=0xFFFFFFFF.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared state encoding, widths and the little-endian byte-lane helper for
// the instruction-memory loader.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 32;

    // 4-bit encoding so the loader state lines up with the core's state width.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_COLLECT    = 4'd1,
        ST_WRITE      = 4'd2,
        ST_NEXT       = 4'd3,
        ST_START_CORE = 4'd4,
        ST_DONE       = 4'd5
    } state_e;

    function automatic logic [IMEM_DATA_W-1:0] place_byte(
        input logic [IMEM_DATA_W-1:0] word,
        input logic [1:0]             idx,
        input logic [7:0]             data
    );
        logic [IMEM_DATA_W-1:0] res;
        res = word;
        case (idx)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            2'd3:    res[31:24] = data;
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte index counter plus 4-byte little-endian assembly register; flags the
// cycle in which the fourth byte of a word is taken.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   take_i,
    input  logic [7:0]             byte_i,
    output logic [IMEM_DATA_W-1:0] word_o,
    output logic                   word_valid_o
);

    logic [1:0]             idx_q;
    logic [1:0]             idx_d;
    logic [IMEM_DATA_W-1:0] asm_q;
    logic [IMEM_DATA_W-1:0] asm_d;

    // Next index / assembly value; word_o already includes the byte being taken.
    always_comb begin
        idx_d        = idx_q;
        asm_d        = asm_q;
        word_valid_o = 1'b0;
        if (clear_i) begin
            idx_d = 2'd0;
        end else if (take_i) begin
            asm_d        = place_byte(asm_q, idx_q, byte_i);
            idx_d        = idx_q + 2'd1;
            word_valid_o = (idx_q == 2'd3);
        end else begin
            idx_d = idx_q;
        end
    end

    assign word_o = asm_d;

    // Index and assembly registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            asm_q <= 32'd0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: collects a byte-serial image, writes 32-bit words into the
// instruction memory, then pulses core_start and reports completion.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int NUM_WORDS = 48,
    parameter int WR_HOLD   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_go,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic [IMEM_ADDR_W-1:0] mem_lo,
    output logic [IMEM_DATA_W-1:0] mem_in,
    output logic                   mem_en,
    output logic                   core_start,
    output logic                   busy,
    output logic                   load_done,
    output logic [7:0]             word_count,
    output logic [IMEM_DATA_W-1:0] checksum
);

    localparam logic [8:0] LAST_CNT  = 9'(NUM_WORDS);
    localparam logic [2:0] HOLD_LAST = 3'(WR_HOLD);

    state_e                 state_q;
    logic [2:0]             hold_q;
    logic                   byte_ready_q;
    logic [IMEM_ADDR_W-1:0] mem_lo_q;
    logic [IMEM_DATA_W-1:0] mem_in_q;
    logic                   mem_en_q;
    logic                   core_start_q;
    logic                   busy_q;
    logic                   load_done_q;
    logic [7:0]             word_count_q;
    logic [IMEM_DATA_W-1:0] checksum_q;

    logic                   take_s;
    logic                   go_s;
    logic                   clear_s;
    logic                   last_word_s;
    logic                   word_valid_s;
    logic [IMEM_DATA_W-1:0] word_s;

    assign take_s      = byte_valid && byte_ready_q;
    assign go_s        = load_go && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign clear_s     = go_s || (state_q == ST_NEXT);
    assign last_word_s = (({1'b0, word_count_q} + 9'd1) == LAST_CNT);

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst),
        .clear_i      (clear_s),
        .take_i       (take_s),
        .byte_i       (byte_data),
        .word_o       (word_s),
        .word_valid_o (word_valid_s)
    );

    // Load sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            hold_q       <= 3'd0;
            byte_ready_q <= 1'b0;
            mem_lo_q     <= 8'd0;
            mem_in_q     <= 32'd0;
            mem_en_q     <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            word_count_q <= 8'd0;
            checksum_q   <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (go_s) begin
                        state_q      <= ST_COLLECT;
                        word_count_q <= 8'd0;
                        checksum_q   <= 32'd0;
                        mem_lo_q     <= 8'd0;
                        byte_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        load_done_q  <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (word_valid_s) begin
                        state_q      <= ST_WRITE;
                        mem_in_q     <= word_s;
                        mem_en_q     <= 1'b1;
                        hold_q       <= 3'd1;
                        byte_ready_q <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q  <= ST_NEXT;
                        mem_en_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 3'd1;
                    end
                end
                ST_NEXT: begin
                    word_count_q <= word_count_q + 8'd1;
                    checksum_q   <= checksum_q ^ mem_in_q;
                    if (last_word_s) begin
                        state_q      <= ST_START_CORE;
                        core_start_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        state_q      <= ST_COLLECT;
                        mem_lo_q     <= mem_lo_q + 8'd1;
                        byte_ready_q <= 1'b1;
                    end
                end
                ST_START_CORE: begin
                    state_q      <= ST_DONE;
                    core_start_q <= 1'b0;
                    load_done_q  <= 1'b1;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    byte_ready_q <= 1'b0;
                    mem_en_q     <= 1'b0;
                    core_start_q <= 1'b0;
                    busy_q       <= 1'b0;
                    load_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_lo     = mem_lo_q;
    assign mem_in     = mem_in_q;
    assign mem_en     = mem_en_q;
    assign core_start = core_start_q;
    assign busy       = busy_q;
    assign load_done  = load_done_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;

endmodule
